// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADD3_THRESH = 5;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

  // Width needed to count 0..v-1; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: add 3 to a digit that is 5 or more.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q_c
);

  logic ge_thresh;

  assign ge_thresh = (d >= BCD_DIGIT_W'(ADD3_THRESH));
  assign q_c       = ge_thresh ? (d + BCD_DIGIT_W'(3)) : d;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Iterative binary-to-BCD converter with start/busy/done handshake.
// One digit-correction slice per digit is reused every shift cycle.
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NDIG  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sign_en,
  input  logic [WIDTH-1:0]           bin,
  output logic                       busy,
  output logic                       done,
  output logic                       negative,
  output logic [BCD_DIGIT_W*NDIG-1:0] bcd
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * NDIG;
  localparam int unsigned CNT_W = clog2(WIDTH);

  logic [STATE_W-1:0] state, state_next;
  logic [WIDTH-1:0]   mag;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_shift;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               last_c;
  logic               load_neg;
  logic [WIDTH-1:0]   load_mag;

  assign last_c   = (cnt == CNT_W'(WIDTH - 1));
  assign load_neg = sign_en & bin[WIDTH-1];
  assign load_mag = load_neg ? (~bin + WIDTH'(1)) : bin;

  // All digits corrected in parallel before the shift.
  for (genvar g = 0; g < NDIG; g++) begin : gen_digit
    bcd_add3_digit u_add3 (
      .d   (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q_c (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top corrected bit is always zero given the digit-count constraint.
  assign scratch_shift = BCD_W'({scratch_adj, mag[WIDTH-1]});

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_c) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs (one cycle behind state).
  always_ff @(posedge clk) begin
    if (rst) begin
      mag      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      negative <= 1'b0;
      bcd      <= '0;
    end else begin
      busy <= (state != ST_IDLE);
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            mag     <= load_mag;
            scratch <= '0;
            cnt     <= '0;
            neg_q   <= load_neg;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_shift;
          mag     <= {mag[WIDTH-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (last_c) begin
            bcd      <= scratch_shift;
            negative <= neg_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed self-checking bench for bcd_convert_ctrl (WIDTH=16, NDIG=5).
module tb_bcd_convert_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign_en;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        negative;
  logic [19:0] bcd;

  int n_checks;
  int n_fail;

  bcd_convert_ctrl #(.WIDTH(16), .NDIG(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign_en  (sign_en),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .negative (negative),
    .bcd      (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] vec_bin  [6] = '{16'h3039, 16'h3039, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF};
  logic        vec_sen  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [19:0] vec_bcd  [6] = '{20'h12345, 20'h12345, 20'h00001, 20'h65535, 20'h32768, 20'h32767};
  logic        vec_neg  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  // Present start for exactly one rising edge, then return #1 after it.
  task automatic do_start(input logic [15:0] b, input logic s);
    bin     = b;
    sign_en = s;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cycles = i + 1;
        seen   = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sign_en = 1'b0; bin = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (negative !== 1'b0) begin n_fail++; $display("FAIL reset_negative got %b exp 0", negative); end
    n_checks++; if (bcd !== 20'h0) begin n_fail++; $display("FAIL reset_bcd got %h exp 00000", bcd); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int busy_cnt, done_cnt, first_done;
    busy_cnt = 0; done_cnt = 0; first_done = 0;
    do_start(16'd0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = i + 1;
      end
    end
    n_checks++; if (first_done != 17) begin n_fail++; $display("FAIL zero_latency got %0d exp 17", first_done); end
    n_checks++; if (busy_cnt != 17) begin n_fail++; $display("FAIL zero_busy_cycles got %0d exp 17", busy_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d exp 1", done_cnt); end
    n_checks++; if (bcd !== 20'h00000) begin n_fail++; $display("FAIL zero_bcd got %h exp 00000", bcd); end
    n_checks++; if (negative !== 1'b0) begin n_fail++; $display("FAIL zero_negative got %b exp 0", negative); end
  endtask

  task automatic test_vectors();
    int cyc;
    bit seen;
    for (int v = 0; v < 6; v++) begin
      do_start(vec_bin[v], vec_sen[v]);
      wait_done(40, cyc, seen);
      n_checks++;
      if (!seen || cyc != 17) begin
        n_fail++;
        $display("FAIL vec%0d_latency got %0d (seen=%0b) exp 17", v, cyc, seen);
      end
      n_checks++;
      if (bcd !== vec_bcd[v]) begin
        n_fail++;
        $display("FAIL vec%0d_bcd bin=%h sign_en=%b got %h exp %h", v, vec_bin[v], vec_sen[v], bcd, vec_bcd[v]);
      end
      n_checks++;
      if (negative !== vec_neg[v]) begin
        n_fail++;
        $display("FAIL vec%0d_negative got %b exp %b", v, negative, vec_neg[v]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    done_cnt = 0;
    do_start(16'd999, 1'b0);
    for (int i = 0; i < 25; i++) begin
      if (i == 4) begin start = 1'b1; bin = 16'd1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (i == 2) begin
        n_checks++;
        if (bcd !== 20'h32767) begin n_fail++; $display("FAIL hold_prev_bcd got %h exp 32767", bcd); end
      end
      if (done) done_cnt++;
    end
    start = 1'b0;
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d exp 1", done_cnt); end
    n_checks++; if (bcd !== 20'h00999) begin n_fail++; $display("FAIL ignore_bcd got %h exp 00999", bcd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    do_start(16'd7, 1'b0);
    wait_done(40, cyc, seen);
    n_checks++; if (!seen || bcd !== 20'h00007) begin n_fail++; $display("FAIL b2b_first got %h (seen=%0b) exp 00007", bcd, seen); end
    do_start(16'd58, 1'b0);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap busy=%b done=%b exp 0 0", busy, done); end
    wait_done(40, cyc, seen);
    n_checks++; if (!seen || cyc != 17) begin n_fail++; $display("FAIL b2b_latency got %0d (seen=%0b) exp 17", cyc, seen); end
    n_checks++; if (bcd !== 20'h00058) begin n_fail++; $display("FAIL b2b_second got %h exp 00058", bcd); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc, done_cnt;
    bit seen;
    do_start(16'd4321, 1'b0);
    wait_done(40, cyc, seen);
    n_checks++; if (!seen || bcd !== 20'h04321) begin n_fail++; $display("FAIL mid_pre got %h (seen=%0b) exp 04321", bcd, seen); end
    @(posedge clk); #1;
    do_start(16'd9876, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_checks++; if (bcd !== 20'h0) begin n_fail++; $display("FAIL mid_bcd got %h exp 00000", bcd); end
    n_checks++; if (negative !== 1'b0) begin n_fail++; $display("FAIL mid_negative got %b exp 0", negative); end
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL mid_no_done got %0d active cycles exp 0", done_cnt); end
    do_start(16'd42, 1'b0);
    wait_done(40, cyc, seen);
    n_checks++; if (!seen || bcd !== 20'h00042) begin n_fail++; $display("FAIL mid_fresh got %h (seen=%0b) exp 00042", bcd, seen); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
